bcd_display_driver: RTL

BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

---
 rtl/bcd_display_driver.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: converts a 14-bit binary value to four BCD digits and scans them onto a 7-segment display.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_display_driver #(
    parameter int         REFRESH_DIV = 1000,
    parameter logic [6:0] BLANK_PAT   = 7'b1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value,
    output logic [6:0]  seg_out,
    output logic [3:0]  digit_sel,
    output logic        busy
);
    localparam int PW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, state_n;
    logic [13:0]   last_value;
    logic [29:0]   sr, sr_adj;
    logic [3:0]    cnt;
    logic [15:0]   digits;
    logic          ovf;
    logic [PW-1:0] presc;
    logic [1:0]    idx, idx_n;
    logic          wrap;
    logic [3:0]    blank;
    logic [3:0]    dsel;
    logic [6:0]    seg_n;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    dec = 7'h3F;
            4'd1:    dec = 7'h06;
            4'd2:    dec = 7'h5B;
            4'd3:    dec = 7'h4F;
            4'd4:    dec = 7'h66;
            4'd5:    dec = 7'h6D;
            4'd6:    dec = 7'h7D;
            4'd7:    dec = 7'h07;
            4'd8:    dec = 7'h7F;
            4'd9:    dec = 7'h6F;
            default: dec = 7'h00;
        endcase
    endfunction

    // Double-dabble correction: bump every BCD nibble >= 5 before the shift
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 4; i++)
            if (sr[14+4*i +: 4] >= 4'd5) sr_adj[14+4*i +: 4] = sr[14+4*i +: 4] + 4'd3;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (value != last_value) ? SHIFT : IDLE;
            SHIFT:   state_n = (cnt == 4'd13) ? DONE : SHIFT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_value <= '0;
            sr         <= '0;
            cnt        <= '0;
            digits     <= '0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (value != last_value) begin
                    sr         <= {16'd0, value};
                    last_value <= value;
                    cnt        <= '0;
                end
                SHIFT: begin
                    sr  <= {sr_adj[28:0], 1'b0};
                    cnt <= cnt + 4'd1;
                end
                default: begin
                    digits <= sr[29:14];
                    ovf    <= last_value > 14'd9999;
                end
            endcase
        end
    end

    assign busy = state != IDLE;

`ifdef LEADING_ZERO_BLANK_EN
    assign blank = {digits[15:12] == 4'd0, digits[15:8] == 8'd0, digits[15:4] == 12'd0, 1'b0};
`else
    assign blank = 4'b0000;
`endif

    // The pattern is computed for the slot being selected next so segments and enable stay aligned
    always_comb begin
        wrap  = presc == PW'(REFRESH_DIV - 1);
        idx_n = wrap ? idx + 2'd1 : idx;
        dsel  = 4'b0001 << idx_n;
        seg_n = ovf ? BLANK_PAT : blank[idx_n] ? 7'h00 : dec(digits[4*idx_n +: 4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            idx       <= '0;
            digit_sel <= 4'b0001;
            seg_out   <= 7'h3F;
        end else begin
            presc     <= wrap ? '0 : presc + 1'b1;
            idx       <= idx_n;
            digit_sel <= dsel;
            seg_out   <= seg_n;
        end
    end
endmodule
